ryu_action_ctrl: RTL and testbench

Per-frame fighter action controller. It produces the 3-bit sprite code and the RyuX/RyuY position consumed by the Ryu sprite selector and renderer. It turns debounced keyboard levels and a death flag into an action state machine with walking, jump physics, timed punches and screen clamping. All state advances only on a one-cycle frame_tick pulse, asserted once per vertical sync.

---
 rtl/ryu_action_ctrl.sv | 125 ++++++++++++
 tb/tb_ryu_action_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ryu_action_ctrl.sv
// ryu_action_ctrl: per-frame fighter action FSM with walking, jump physics, timed punches and X clamping
module ryu_action_ctrl #(
  parameter int X_INIT       = 100,
  parameter int Y_GROUND     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1,
  parameter int PUNCH_FRAMES = 12
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_punch,
  input  logic       dead,
  output logic [2:0] sprite,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic       attack_active,
  output logic       busy
);
  typedef enum logic [2:0] {STAND, PUNCH, JUMP, CROUCH, WALK_L, WALK_R, DEATH, JUMP_ATK} state_t;
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YG_S   = 11'(Y_GROUND);
  localparam logic signed [10:0] STEP_S = 11'(WALK_STEP);
  state_t state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, x_left, x_right;
  logic signed [5:0] vy_q, vy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] drift_q, drift_d;
  logic prev_q, prev_d, atk_q, atk_d, busy_q, busy_d;
  logic signed [10:0] x_l, x_r, y_nx;
  logic punch_edge, air, land;
  assign punch_edge = key_punch & ~prev_q;
  assign air = (state_q == JUMP) || (state_q == JUMP_ATK);
  assign x_l = $signed({1'b0, x_q}) - STEP_S;
  assign x_r = $signed({1'b0, x_q}) + STEP_S;
  assign x_left = x_l < XMIN_S ? 10'(X_MIN) : x_l[9:0];
  assign x_right = x_r > XMAX_S ? 10'(X_MAX) : x_r[9:0];
  assign y_nx = $signed({1'b0, y_q}) - $signed({{5{vy_q[5]}}, vy_q});
  assign land = y_nx >= YG_S;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    vy_d = vy_q;
    cnt_d = cnt_q;
    drift_d = drift_q;
    prev_d = prev_q;
    if (frame_tick) begin
      prev_d = key_punch;
      if (dead) begin
        state_d = DEATH;
        y_d = 10'(Y_GROUND);
        vy_d = '0;
      end else if (state_q == PUNCH) begin
        state_d = cnt_q == 4'd0 ? STAND : PUNCH;
        cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end else if (air) begin
        x_d = drift_q[0] ? x_left : drift_q[1] ? x_right : x_q;
        y_d = land ? 10'(Y_GROUND) : y_nx[9:0];
        vy_d = land ? 6'sd0 : vy_q - 6'(GRAVITY);
        state_d = land ? STAND : (state_q == JUMP && punch_edge) ? JUMP_ATK : state_q;
      end else if (state_q != DEATH) begin
        // ground states: jump beats punch beats crouch beats walking
        if (key_up) begin
          state_d = JUMP;
          vy_d = 6'(JUMP_V0);
          drift_d = {key_right & ~key_left, key_left & ~key_right};
        end else if (punch_edge) begin
          state_d = PUNCH;
          cnt_d = 4'(PUNCH_FRAMES - 1);
        end else if (key_down) begin
          state_d = CROUCH;
        end else if (key_left & key_right) begin
          state_d = STAND;
        end else if (key_left) begin
          state_d = WALK_L;
          x_d = x_left;
        end else if (key_right) begin
          state_d = WALK_R;
          x_d = x_right;
        end else begin
          state_d = STAND;
        end
      end
    end
    atk_d = (state_d == PUNCH) || (state_d == JUMP_ATK);
    busy_d = atk_d || (state_d == JUMP) || (state_d == DEATH);
  end
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= STAND;
      x_q <= 10'(X_INIT);
      y_q <= 10'(Y_GROUND);
      vy_q <= '0;
      cnt_q <= '0;
      drift_q <= '0;
      prev_q <= 1'b0;
      atk_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      vy_q <= vy_d;
      cnt_q <= cnt_d;
      drift_q <= drift_d;
      prev_q <= prev_d;
      atk_q <= atk_d;
      busy_q <= busy_d;
    end
  end
  assign sprite = state_q;
  assign RyuX = x_q;
  assign RyuY = y_q;
  assign attack_active = atk_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ryu_action_ctrl.sv
// tb_ryu_action_ctrl: scenario tasks plus randomized run against an arithmetic action model
module tb_ryu_action_ctrl;
  logic vga_clk = 0, Reset = 0, frame_tick = 0;
  logic kl = 0, kr = 0, ku = 0, kd = 0, kp = 0, dd = 0;
  logic [2:0] sprite;
  logic [9:0] RyuX, RyuY;
  logic attack_active, busy;
  logic [24:0] obs;
  int n_tests = 0, n_fail = 0;
  localparam int S_STAND = 0, S_PUNCH = 1, S_JUMP = 2, S_CROUCH = 3, S_WL = 4, S_WR = 5, S_DEATH = 6, S_JATK = 7;
  int m_st, m_x, m_y, m_k, m_drift, m_pleft;
  bit m_prev;

  ryu_action_ctrl dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick),
    .key_left(kl), .key_right(kr), .key_up(ku), .key_down(kd), .key_punch(kp), .dead(dd),
    .sprite(sprite), .RyuX(RyuX), .RyuY(RyuY), .attack_active(attack_active), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;
  assign obs = {sprite, RyuX, RyuY, attack_active, busy};

  function automatic int clampx(input int x);
    return x < 0 ? 0 : (x > 560 ? 560 : x);
  endfunction

  function automatic logic [24:0] exp_vec();
    bit atk, bsy;
    atk = (m_st == S_PUNCH) || (m_st == S_JATK);
    bsy = atk || (m_st == S_JUMP) || (m_st == S_DEATH);
    return {3'(m_st), 10'(m_x), 10'(m_y), atk, bsy};
  endfunction

  task automatic model_reset();
    m_st = S_STAND; m_x = 100; m_y = 300; m_k = 0; m_drift = 0; m_pleft = 0; m_prev = 0;
  endtask

  // Height is taken from the closed-form ballistic curve of ticks since take-off.
  task automatic model_step();
    bit pe;
    int ny;
    pe = kp && !m_prev;
    m_prev = kp;
    if (dd) begin
      m_st = S_DEATH; m_y = 300; m_k = 0;
    end else if (m_st == S_DEATH) begin
    end else if (m_st == S_PUNCH) begin
      if (m_pleft == 0) m_st = S_STAND; else m_pleft--;
    end else if (m_st == S_JUMP || m_st == S_JATK) begin
      m_k++;
      ny = 300 - (12 * m_k - m_k * (m_k - 1) / 2);
      m_x = clampx(m_x + 2 * m_drift);
      if (ny >= 300) begin m_y = 300; m_st = S_STAND; m_k = 0; end
      else begin m_y = ny; if (m_st == S_JUMP && pe) m_st = S_JATK; end
    end else if (ku) begin
      m_st = S_JUMP; m_k = 0;
      m_drift = (kl && !kr) ? -1 : (kr && !kl) ? 1 : 0;
    end else if (pe) begin
      m_st = S_PUNCH; m_pleft = 11;
    end else if (kd) m_st = S_CROUCH;
    else if (kl && kr) m_st = S_STAND;
    else if (kl) begin m_st = S_WL; m_x = clampx(m_x - 2); end
    else if (kr) begin m_st = S_WR; m_x = clampx(m_x + 2); end
    else m_st = S_STAND;
  endtask

  task automatic tick(input int gap);
    @(negedge vga_clk);
    frame_tick = 1;
    @(negedge vga_clk);
    frame_tick = 0;
    model_step();
    repeat (gap) @(negedge vga_clk);
  endtask

  task automatic do_reset();
    #2 Reset = 1;
    model_reset();
    #1;
  endtask

  task automatic set_keys(input logic [5:0] k);
    {kl, kr, ku, kd, kp, dd} = k;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs, exp_vec()); end
    @(negedge vga_clk);
    Reset = 0;
    set_keys(6'b0);
    for (int i = 1; i <= 10; i++) begin
      tick(i % 3);
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL idle tick %0d: got %h expected %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_walk();
    set_keys(6'b010000);
    for (int i = 1; i <= 300; i++) begin
      tick(0);
      n_tests++;
      if (obs !== exp_vec() || RyuX > 10'd560) begin n_fail++; $display("FAIL walk_right tick %0d: got %h expected %h", i, obs, exp_vec()); end
    end
    set_keys(6'b100000);
    for (int i = 1; i <= 300; i++) begin
      tick(0);
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL walk_left tick %0d: got %h expected %h", i, obs, exp_vec()); end
    end
    n_tests++;
    if (RyuX !== 10'd0 || sprite !== 3'd4) begin n_fail++; $display("FAIL walk_left_clamp: got x=%0d spr=%0d expected x=0 spr=4", RyuX, sprite); end
    set_keys(6'b0);
    tick(0);
  endtask

  task automatic test_jump();
    set_keys(6'b001000);
    tick(0);
    set_keys(6'b0);
    for (int k = 1; k <= 25; k++) begin
      tick(k % 2);
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL jump tick %0d: got %h expected %h", k, obs, exp_vec()); end
      if (k == 1 || k == 12 || k == 25) begin
        n_tests++;
        if (RyuY !== (k == 1 ? 10'd288 : k == 12 ? 10'd222 : 10'd300) || sprite !== (k == 25 ? 3'd0 : 3'd2) || busy !== (k != 25))
          begin n_fail++; $display("FAIL jump_key tick %0d: got y=%0d spr=%0d busy=%0b", k, RyuY, sprite, busy); end
      end
    end
  endtask

  task automatic test_punch();
    int n;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      set_keys(6'b000010);
      for (int i = 1; i <= 30; i++) begin
        tick(0);
        if (sprite === 3'd1 && attack_active === 1'b1) n++;
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL punch round %0d tick %0d: got %h expected %h", r, i, obs, exp_vec()); end
      end
      n_tests++;
      if (n != 12) begin n_fail++; $display("FAIL punch_len round %0d: got %0d ticks expected 12", r, n); end
      set_keys(6'b0);
      tick(0);
    end
  endtask

  task automatic test_jump_attack();
    set_keys(6'b001000);
    tick(0);
    for (int k = 1; k <= 25; k++) begin
      set_keys({4'b0, (k >= 5 && k <= 6) || (k >= 9 && k <= 10), 1'b0});
      tick(0);
      n_tests++;
      if (obs !== exp_vec() || sprite !== (k < 5 ? 3'd2 : k < 25 ? 3'd7 : 3'd0))
        begin n_fail++; $display("FAIL jump_atk tick %0d: got %h expected %h", k, obs, exp_vec()); end
    end
    set_keys(6'b0);
    tick(0);
  endtask

  task automatic test_death();
    set_keys(6'b001000);
    tick(0);
    set_keys(6'b0);
    for (int k = 1; k <= 8; k++) begin
      dd = (k == 8);
      tick(0);
    end
    n_tests++;
    if (sprite !== 3'd6 || RyuY !== 10'd300 || busy !== 1'b1 || obs !== exp_vec())
      begin n_fail++; $display("FAIL death_entry: got %h expected %h", obs, exp_vec()); end
    for (int i = 0; i < 20; i++) begin
      set_keys(6'($urandom));
      tick(0);
      n_tests++;
      if (sprite !== 3'd6 || obs !== exp_vec()) begin n_fail++; $display("FAIL death_sticky %0d: got %h expected %h", i, obs, exp_vec()); end
    end
    do_reset();
    @(negedge vga_clk);
    Reset = 0;
    set_keys(6'b011000);
    tick(0);
    set_keys(6'b010000);
    repeat (6) tick(0);
    n_tests++;
    if (RyuX === 10'd100 || obs !== exp_vec()) begin n_fail++; $display("FAIL drift_jump: got %h expected %h", obs, exp_vec()); end
    do_reset();
    n_tests++;
    if (RyuX !== 10'd100 || RyuY !== 10'd300 || sprite !== 3'd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_midjump: got %h expected x=100 y=300 spr=0", obs); end
    @(negedge vga_clk);
    Reset = 0;
    set_keys(6'b0);
  endtask

  task automatic test_random();
    logic [5:0] k;
    for (int i = 0; i < 1500; i++) begin
      k = 6'($urandom);
      k[0] = ($urandom_range(0, 99) == 0);
      k[3] = k[3] & ($urandom_range(0, 3) == 0);
      set_keys(k);
      tick($urandom_range(0, 2));
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random step %0d: got %h expected %h", i, obs, exp_vec()); end
      if (m_st == S_DEATH && $urandom_range(0, 3) == 0) begin
        do_reset();
        @(negedge vga_clk);
        Reset = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_jump();
    test_punch();
    test_jump_attack();
    test_death();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
